// File: rtl/alarm_clock_ctrl_pkg.sv
// Shared state encoding and field limits for the alarm clock controller.
package clock_pkg;

  localparam int HOURS_W = 5;
  localparam int MINS_W  = 6;

  localparam logic [HOURS_W-1:0] HOURS_MAX = 5'd23;
  localparam logic [MINS_W-1:0]  MINS_MAX  = 6'd59;

  typedef enum logic [2:0] {
    NORMAL        = 3'd0,
    SET_TIME_HR   = 3'd1,
    SET_TIME_MIN  = 3'd2,
    SET_ALARM_HR  = 3'd3,
    SET_ALARM_MIN = 3'd4
  } state_t;

  function automatic state_t next_mode(input state_t s);
    case (s)
      NORMAL:        return SET_TIME_HR;
      SET_TIME_HR:   return SET_TIME_MIN;
      SET_TIME_MIN:  return SET_ALARM_HR;
      SET_ALARM_HR:  return SET_ALARM_MIN;
      default:       return NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/alarm_clock_ctrl_hm_counter.sv
// HH:MM register: carrying minute increment plus wrap-only hour and minute edits.
// inc_min_i wins over the edit strobes; callers never raise them together.
module hm_counter
  import clock_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               inc_min_i,
  input  logic               inc_hr_i,
  input  logic               inc_min_nocarry_i,
  output logic [HOURS_W-1:0] hours_o,
  output logic [MINS_W-1:0]  mins_o
);

  logic [HOURS_W-1:0] hours_q, hours_d, hours_inc;
  logic [MINS_W-1:0]  mins_q, mins_d, mins_inc;

  assign hours_inc = (hours_q == HOURS_MAX) ? '0 : hours_q + HOURS_W'(1);
  assign mins_inc  = (mins_q == MINS_MAX) ? '0 : mins_q + MINS_W'(1);

  always_comb begin
    hours_d = hours_q;
    mins_d  = mins_q;
    if (inc_min_i) begin
      mins_d = mins_inc;
      if (mins_q == MINS_MAX) hours_d = hours_inc;
    end else if (inc_min_nocarry_i) begin
      mins_d = mins_inc;
    end else if (inc_hr_i) begin
      hours_d = hours_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hours_q <= '0;
      mins_q  <= '0;
    end else begin
      hours_q <= hours_d;
      mins_q  <= mins_d;
    end
  end

  assign hours_o = hours_q;
  assign mins_o  = mins_q;

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock sequencer: minute counting, key-driven set-mode FSM and alarm ring control.
// Display, fast_mode and tg_reset are registered one cycle behind the state they reflect.
module alarm_clock_ctrl
  import clock_pkg::*;
#(
  parameter int RING_MINUTES = 1
) (
  input  logic               clk256,
  input  logic               reset_n,
  input  logic               one_minute,
  input  logic               key_mode,
  input  logic               key_adv,
  input  logic               key_stop,
  input  logic               key_fast,
  input  logic               alarm_en,
  output logic               fast_mode,
  output logic               tg_reset,
  output logic [HOURS_W-1:0] disp_hours,
  output logic [MINS_W-1:0]  disp_mins,
  output logic               disp_sel,
  output logic [2:0]         mode_state,
  output logic               alarm_ring
);

  localparam logic [5:0] RING_LIM = 6'(RING_MINUTES);

  logic               rst_meta_q, rst_sync_q;
  state_t             state_q, state_d;
  logic               min_q, min_prev_q, ticked_q;
  logic               ring_q, ring_d;
  logic [5:0]         ring_cnt_q, ring_cnt_d;
  logic               fast_q, tg_q, sel_q;
  logic [HOURS_W-1:0] disp_hours_q, time_hours, alarm_hours;
  logic [MINS_W-1:0]  disp_mins_q, time_mins, alarm_mins;
  logic               minute_tick, time_frozen, show_alarm, adv;
  logic               alarm_match, ring_expire;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign minute_tick = min_q & ~min_prev_q;
  assign time_frozen = (state_q == SET_TIME_HR) || (state_q == SET_TIME_MIN);
  assign show_alarm  = (state_q == SET_ALARM_HR) || (state_q == SET_ALARM_MIN);
  assign adv         = key_adv & ~key_mode;
  assign state_d     = key_mode ? next_mode(state_q) : state_q;

  hm_counter u_time (
    .clk_i             (clk256),
    .rst_n_i           (rst_sync_q),
    .inc_min_i         (minute_tick & ~time_frozen),
    .inc_hr_i          (adv & (state_q == SET_TIME_HR)),
    .inc_min_nocarry_i (adv & (state_q == SET_TIME_MIN)),
    .hours_o           (time_hours),
    .mins_o            (time_mins)
  );

  hm_counter u_alarm (
    .clk_i             (clk256),
    .rst_n_i           (rst_sync_q),
    .inc_min_i         (1'b0),
    .inc_hr_i          (adv & (state_q == SET_ALARM_HR)),
    .inc_min_nocarry_i (adv & (state_q == SET_ALARM_MIN)),
    .hours_o           (alarm_hours),
    .mins_o            (alarm_mins)
  );

  // ticked_q marks the cycle where time has just been advanced by a tick in NORMAL,
  // so key edits can never produce a match.
  assign alarm_match = ticked_q & (state_q == NORMAL) & alarm_en &
                       (time_hours == alarm_hours) & (time_mins == alarm_mins);

  always_comb begin
    ring_d      = ring_q;
    ring_cnt_d  = ring_cnt_q;
    ring_expire = 1'b0;
    if (ring_q && minute_tick) begin
      ring_cnt_d  = ring_cnt_q + 6'd1;
      ring_expire = (ring_cnt_q + 6'd1) == RING_LIM;
    end
    if (alarm_match) begin
      ring_d     = 1'b1;
      ring_cnt_d = '0;
    end
    if (key_stop || !alarm_en || (state_d != NORMAL) || ring_expire) ring_d = 1'b0;
  end

  always_ff @(posedge clk256 or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q      <= NORMAL;
      min_q        <= 1'b0;
      min_prev_q   <= 1'b0;
      ticked_q     <= 1'b0;
      ring_q       <= 1'b0;
      ring_cnt_q   <= '0;
      fast_q       <= 1'b0;
      tg_q         <= 1'b0;
      sel_q        <= 1'b0;
      disp_hours_q <= '0;
      disp_mins_q  <= '0;
    end else begin
      state_q      <= state_d;
      min_q        <= one_minute;
      min_prev_q   <= min_q;
      ticked_q     <= minute_tick & (state_q == NORMAL);
      ring_q       <= ring_d;
      ring_cnt_q   <= ring_cnt_d;
      fast_q       <= key_fast & (state_q == NORMAL);
      tg_q         <= key_mode & (state_q == SET_TIME_MIN);
      sel_q        <= show_alarm;
      disp_hours_q <= show_alarm ? alarm_hours : time_hours;
      disp_mins_q  <= show_alarm ? alarm_mins : time_mins;
    end
  end

  assign fast_mode  = fast_q;
  assign tg_reset   = tg_q;
  assign disp_hours = disp_hours_q;
  assign disp_mins  = disp_mins_q;
  assign disp_sel   = sel_q;
  assign mode_state = state_q;
  assign alarm_ring = ring_q;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: constant vector table, directed corner sequences and
// random stimulus, all compared each cycle against a minutes-of-day reference model.
module tb_alarm_clock_ctrl;

  localparam int RING = 1;

  typedef struct packed { logic om, km, ka, ks, kf, ae; } in_t;
  typedef struct packed {
    logic fast; logic tg; logic [4:0] dh; logic [5:0] dm; logic sel; logic [2:0] st; logic ring;
  } out_t;
  typedef struct { in_t in; out_t exp; } vec_t;

  logic clk256 = 1'b0, reset_n = 1'b1;
  logic one_minute = 0, key_mode = 0, key_adv = 0, key_stop = 0, key_fast = 0, alarm_en = 0;
  logic fast_mode, tg_reset, disp_sel, alarm_ring;
  logic [4:0] disp_hours;
  logic [5:0] disp_mins;
  logic [2:0] mode_state;

  always #5 clk256 = ~clk256;

  alarm_clock_ctrl #(.RING_MINUTES(RING)) dut (
    .clk256(clk256), .reset_n(reset_n), .one_minute(one_minute), .key_mode(key_mode),
    .key_adv(key_adv), .key_stop(key_stop), .key_fast(key_fast), .alarm_en(alarm_en),
    .fast_mode(fast_mode), .tg_reset(tg_reset), .disp_hours(disp_hours), .disp_mins(disp_mins),
    .disp_sel(disp_sel), .mode_state(mode_state), .alarm_ring(alarm_ring)
  );

  int n_cmp = 0, n_err = 0;
  logic g_kf = 0, g_ae = 0, g_om = 0;
  vec_t tbl[20];

  // Reference model: time and alarm as minutes since midnight, state as 0..4.
  int   m_time, m_alarm, m_st, m_rcnt, m_dh, m_dm;
  logic m_om1, m_om2, m_new_min, m_ring, m_fast, m_tg, m_sel;

  function automatic int bump_hr(input int t);
    return ((t / 60 + 1) % 24) * 60 + t % 60;
  endfunction
  function automatic int bump_min(input int t);
    return (t / 60) * 60 + (t % 60 + 1) % 60;
  endfunction

  task automatic m_reset();
    m_time = 0; m_alarm = 0; m_st = 0; m_rcnt = 0; m_dh = 0; m_dm = 0;
    m_om1 = 0; m_om2 = 0; m_new_min = 0; m_ring = 0; m_fast = 0; m_tg = 0; m_sel = 0;
  endtask

  task automatic m_update(input in_t v);
    logic tick, adv, match, ring_n;
    int st_n, t_n, a_n, rcnt_n;
    tick  = m_om1 && !m_om2;
    st_n  = v.km ? (m_st + 1) % 5 : m_st;
    adv   = v.ka && !v.km;
    t_n   = m_time;
    a_n   = m_alarm;
    if (tick && m_st != 1 && m_st != 2) t_n = (m_time + 1) % 1440;
    if (adv) begin
      if (m_st == 1) t_n = bump_hr(m_time);
      if (m_st == 2) t_n = bump_min(m_time);
      if (m_st == 3) a_n = bump_hr(m_alarm);
      if (m_st == 4) a_n = bump_min(m_alarm);
    end
    match  = m_new_min && m_st == 0 && v.ae && m_time == m_alarm;
    ring_n = m_ring;
    rcnt_n = m_rcnt;
    if (m_ring && tick) rcnt_n = m_rcnt + 1;
    if (match) begin ring_n = 1; rcnt_n = 0; end
    if (v.ks || !v.ae || st_n != 0 || (m_ring && tick && rcnt_n >= RING)) ring_n = 0;
    m_fast = v.kf && m_st == 0;
    m_tg   = v.km && m_st == 2;
    m_sel  = (m_st == 3 || m_st == 4);
    m_dh   = (m_sel ? m_alarm : m_time) / 60;
    m_dm   = (m_sel ? m_alarm : m_time) % 60;
    m_new_min = tick && m_st == 0;
    m_om2 = m_om1; m_om1 = v.om;
    m_time = t_n; m_alarm = a_n; m_st = st_n; m_ring = ring_n; m_rcnt = rcnt_n;
  endtask

  function automatic out_t act();
    return {fast_mode, tg_reset, disp_hours, disp_mins, disp_sel, mode_state, alarm_ring};
  endfunction
  function automatic out_t m_exp();
    return {m_fast, m_tg, 5'(m_dh), 6'(m_dm), m_sel, 3'(m_st), m_ring};
  endfunction
  function automatic in_t mk(input logic om, km, ka, ks);
    return {om, km, ka, ks, g_kf, g_ae};
  endfunction

  task automatic check_out(input string name, input out_t a, input out_t e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got fast=%0b tg=%0b %0d:%0d sel=%0b st=%0d ring=%0b, want fast=%0b tg=%0b %0d:%0d sel=%0b st=%0d ring=%0b",
               name, a.fast, a.tg, a.dh, a.dm, a.sel, a.st, a.ring,
               e.fast, e.tg, e.dh, e.dm, e.sel, e.st, e.ring);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, a, e);
    end
  endtask

  // Called at a negedge: drive, advance the model, then compare at the next negedge.
  task automatic step(input in_t v);
    {one_minute, key_mode, key_adv, key_stop, key_fast, alarm_en} = v;
    m_update(v);
    @(posedge clk256);
    @(negedge clk256);
    check_out("model", act(), m_exp());
  endtask

  task automatic do_reset();
    g_kf = 0; g_ae = 0; g_om = 0;
    {one_minute, key_mode, key_adv, key_stop, key_fast, alarm_en} = '0;
    reset_n = 1'b0;
    #1;
    check_out("reset_async", act(), '0);
    m_reset();
    repeat (2) @(negedge clk256);
    reset_n = 1'b1;
    repeat (3) step('0);
  endtask

  task automatic tick_pulse();
    step(mk(1, 0, 0, 0));
    step(mk(1, 0, 0, 0));
    step(mk(0, 0, 0, 0));
  endtask

  // Walks the full set-mode cycle from NORMAL back to NORMAL, editing each field.
  task automatic set_clock(input int th, input int tm, input int ah, input int am);
    step(mk(0, 1, 0, 0));
    repeat ((th - m_time / 60 + 24) % 24) step(mk(0, 0, 1, 0));
    step(mk(0, 1, 0, 0));
    repeat ((tm - m_time % 60 + 60) % 60) step(mk(0, 0, 1, 0));
    step(mk(0, 1, 0, 0));
    repeat ((ah - m_alarm / 60 + 24) % 24) step(mk(0, 0, 1, 0));
    step(mk(0, 1, 0, 0));
    repeat ((am - m_alarm % 60 + 60) % 60) step(mk(0, 0, 1, 0));
    step(mk(0, 1, 0, 0));
    step(mk(0, 0, 0, 0));
  endtask

  function automatic vec_t row(input logic [5:0] i, input logic fast, tg, input int dh, dm,
                               input logic sel, input int st, input logic ring);
    vec_t r;
    r.in  = i;
    r.exp = {fast, tg, 5'(dh), 6'(dm), sel, 3'(st), ring};
    return r;
  endfunction

  initial begin
    // inputs {om,km,ka,ks,kf,ae}; expected fast tg hh mm sel state ring
    tbl[0]  = row(6'b000010, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = row(6'b010010, 1, 0, 0, 0, 0, 1, 0);
    tbl[2]  = row(6'b000010, 0, 0, 0, 0, 0, 1, 0);
    tbl[3]  = row(6'b001000, 0, 0, 0, 0, 0, 1, 0);
    tbl[4]  = row(6'b000000, 0, 0, 1, 0, 0, 1, 0);
    tbl[5]  = row(6'b011000, 0, 0, 1, 0, 0, 2, 0);
    tbl[6]  = row(6'b001000, 0, 0, 1, 0, 0, 2, 0);
    tbl[7]  = row(6'b000000, 0, 0, 1, 1, 0, 2, 0);
    tbl[8]  = row(6'b010000, 0, 1, 1, 1, 0, 3, 0);
    tbl[9]  = row(6'b000000, 0, 0, 0, 0, 1, 3, 0);
    tbl[10] = row(6'b001000, 0, 0, 0, 0, 1, 3, 0);
    tbl[11] = row(6'b010000, 0, 0, 1, 0, 1, 4, 0);
    tbl[12] = row(6'b001000, 0, 0, 1, 0, 1, 4, 0);
    tbl[13] = row(6'b000000, 0, 0, 1, 1, 1, 4, 0);
    tbl[14] = row(6'b010000, 0, 0, 1, 1, 1, 0, 0);
    tbl[15] = row(6'b000000, 0, 0, 1, 1, 0, 0, 0);
    tbl[16] = row(6'b100000, 0, 0, 1, 1, 0, 0, 0);
    tbl[17] = row(6'b100000, 0, 0, 1, 1, 0, 0, 0);
    tbl[18] = row(6'b000000, 0, 0, 1, 2, 0, 0, 0);
    tbl[19] = row(6'b000000, 0, 0, 1, 2, 0, 0, 0);

    m_reset();
    repeat (4) @(negedge clk256);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].in);
      check_out($sformatf("table[%0d]", i), act(), tbl[i].exp);
    end

    // Midnight and hour carry.
    do_reset();
    set_clock(23, 59, 0, 0);
    tick_pulse();
    check_int("wrap_2359_h", disp_hours, 0);
    check_int("wrap_2359_m", disp_mins, 0);
    set_clock(10, 59, 0, 0);
    tick_pulse();
    check_int("carry_1059_h", disp_hours, 11);
    check_int("carry_1059_m", disp_mins, 0);

    // Field edits wrap without carry; tg_reset pulse on leaving SET_TIME_MIN.
    do_reset();
    step(mk(0, 1, 0, 0));
    repeat (25) step(mk(0, 0, 1, 0));
    step(mk(0, 0, 0, 0));
    check_int("adv25_hours", disp_hours, 1);
    step(mk(0, 1, 0, 0));
    repeat (61) step(mk(0, 0, 1, 0));
    step(mk(0, 0, 0, 0));
    check_int("adv61_mins", disp_mins, 1);
    check_int("adv61_hours", disp_hours, 1);
    step(mk(0, 1, 0, 0));
    check_int("tg_pulse_hi", tg_reset, 1);
    step(mk(0, 1, 0, 0));
    check_int("tg_pulse_lo", tg_reset, 0);
    step(mk(0, 1, 0, 0));
    check_int("back_normal", mode_state, 0);

    // Alarm ring, timeout after one further tick, and key_stop.
    g_ae = 1;
    set_clock(5, 59, 6, 0);
    check_int("ring_before", alarm_ring, 0);
    tick_pulse();
    check_int("ring_rise", alarm_ring, 1);
    check_int("ring_at_h", disp_hours, 6);
    check_int("ring_at_m", disp_mins, 0);
    tick_pulse();
    check_int("ring_timeout", alarm_ring, 0);
    set_clock(5, 59, 6, 0);
    tick_pulse();
    check_int("ring_rise2", alarm_ring, 1);
    step(mk(0, 0, 0, 1));
    check_int("ring_stop", alarm_ring, 0);

    // Reset mid-ring at 07:30.
    set_clock(7, 29, 7, 30);
    tick_pulse();
    check_int("ring_0730", alarm_ring, 1);
    check_int("ring_0730_m", disp_mins, 30);
    step(mk(0, 0, 0, 0));
    do_reset();

    // Frozen time while setting, ticking while setting alarm, key priority.
    set_clock(12, 0, 3, 0);
    step(mk(0, 1, 0, 0));
    tick_pulse();
    step(mk(0, 0, 0, 0));
    check_int("frozen_m", disp_mins, 0);
    repeat (3) step(mk(0, 1, 0, 0));
    tick_pulse();
    check_int("alarm_disp_h", disp_hours, 3);
    check_int("alarm_disp_sel", disp_sel, 1);
    step(mk(0, 1, 0, 0));
    step(mk(0, 0, 0, 0));
    check_int("time_ran_m", disp_mins, 1);
    check_int("time_ran_sel", disp_sel, 0);
    step(mk(0, 1, 1, 0));
    step(mk(0, 0, 0, 0));
    check_int("prio_state", mode_state, 1);
    check_int("prio_hours", disp_hours, 12);
    repeat (4) step(mk(0, 1, 0, 0));

    // Fast mode gating and disarmed alarm.
    g_kf = 1;
    step(mk(0, 0, 0, 0));
    check_int("fast_on", fast_mode, 1);
    step(mk(0, 1, 0, 0));
    step(mk(0, 0, 0, 0));
    check_int("fast_off_set", fast_mode, 0);
    repeat (4) step(mk(0, 1, 0, 0));
    g_kf = 0;
    set_clock(8, 59, 9, 0);
    tick_pulse();
    check_int("no_ring_disarmed", alarm_ring, 0);

    // Random traffic against the model, starting near an armed alarm.
    g_ae = 1;
    set_clock(13, 58, 14, 0);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(5) == 0) g_om = ~g_om;
      if ($urandom_range(59) == 0) g_ae = ~g_ae;
      if ($urandom_range(29) == 0) g_kf = ~g_kf;
      step(mk(g_om, $urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
